adder_u_arbiter: RTL

//  Shares one saturating unsigned adder (adder_u) among N requesters.
//  A round-robin FSM grants one requester at a time, latches its operands and runs the shared adder.
//  It then presents a registered result tagged with the requester ID and holds it until the consumer acks.

---
 rtl/adder_u_arbiter_pkg.sv | 15 +
 rtl/adder_u_arbiter_if.sv | 29 ++
 rtl/adder_u_arbiter_adder_u.sv | 19 +
 rtl/adder_u_arbiter_rr_pick.sv | 27 ++
 rtl/adder_u_arbiter.sv | 114 +++++++++++
 5 files changed

// File: rtl/adder_u_arbiter_pkg.sv
// Shared types and defaults for the round-robin adder arbiter slice.
package adder_arb_pkg;

  // Arbiter control states: wait for a request, run the adder, hold the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Default datapath width and requester count.
  localparam int DEF_W = 4;
  localparam int DEF_N = 4;

endpackage

// File: rtl/adder_u_arbiter_if.sv
// Bundle of the requester/consumer signals around the shared adder.
// The arbiter uses the slave view; producers and the consumer use the master view.
interface adder_u_arbiter_if #(
  parameter int W = 4,
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req_i;
  logic [N*W-1:0] x_i;
  logic [N*W-1:0] y_i;
  logic [N-1:0]   gnt_o;
  logic [W-1:0]   sum_o;
  logic           of_o;
  logic [IDW-1:0] id_o;
  logic           valid_o;
  logic           ack_i;
  logic           busy_o;

  modport slave (
    input  req_i, x_i, y_i, ack_i,
    output gnt_o, sum_o, of_o, id_o, valid_o, busy_o
  );

  modport master (
    output req_i, x_i, y_i, ack_i,
    input  gnt_o, sum_o, of_o, id_o, valid_o, busy_o
  );
endinterface

// File: rtl/adder_u_arbiter_adder_u.sv
// Saturating unsigned adder: clamps to all-ones when the carry-out is set
// and reports that carry as overflow.
module adder_u #(
  parameter int W = 4
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] sum_o,
  output logic         of_o
);
  logic [W:0] full_sum;

  // One extra bit holds the carry; a set carry forces the saturated value.
  always_comb begin
    full_sum = {1'b0, x_i} + {1'b0, y_i};
    of_o     = full_sum[W];
    sum_o    = full_sum[W] ? {W{1'b1}} : full_sum[W-1:0];
  end
endmodule

// File: rtl/adder_u_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit
// scanning upward from the slot after the last winner, wrapping at N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 any_o,
  output logic [$clog2(N)-1:0] win_o
);
  localparam int IDW = $clog2(N);

  // Scan ptr+1 .. ptr+N (mod N); the last winner is visited last.
  always_comb begin
    int idx;
    any_o = 1'b0;
    win_o = '0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[idx]) begin
        any_o = 1'b1;
        win_o = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/adder_u_arbiter.sv
// Round-robin arbiter sharing one saturating adder among N requesters.
// A grant latches the winner's operands, the next cycle runs the adder,
// and the tagged result is held until the consumer acknowledges it.
module adder_u_arbiter
  import adder_arb_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic               clk_i,
  input  logic               rst_i,
  adder_u_arbiter_if.slave   bus
);
  localparam int IDW = $clog2(N);

  state_t         state_q;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] owner_q;
  logic [W-1:0]   xa_q;
  logic [W-1:0]   ya_q;
  logic [N-1:0]   gnt_q;
  logic [W-1:0]   sum_q;
  logic           of_q;
  logic [IDW-1:0] id_q;
  logic           valid_q;

  logic [W-1:0]   x_arr [N];
  logic [W-1:0]   y_arr [N];
  logic           any_req;
  logic [IDW-1:0] win;
  logic [N-1:0]   gnt_d;
  logic [W-1:0]   add_sum;
  logic           add_of;

  // Split the packed operand buses into per-requester lanes.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign x_arr[gi] = bus.x_i[gi*W +: W];
    assign y_arr[gi] = bus.y_i[gi*W +: W];
  end

  rr_pick #(.N(N)) u_pick (
    .req_i (bus.req_i),
    .ptr_i (ptr_q),
    .any_o (any_req),
    .win_o (win)
  );

  // The single shared datapath only ever sees the latched operands.
  adder_u #(.W(W)) u_add (
    .x_i   (xa_q),
    .y_i   (ya_q),
    .sum_o (add_sum),
    .of_o  (add_of)
  );

  assign gnt_d = N'(1) << win;

  // Control FSM with registered grant and result outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(N-1);
      owner_q <= '0;
      xa_q    <= '0;
      ya_q    <= '0;
      gnt_q   <= '0;
      sum_q   <= '0;
      of_q    <= 1'b0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q <= '0;
          if (any_req) begin
            xa_q    <= x_arr[win];
            ya_q    <= y_arr[win];
            gnt_q   <= gnt_d;
            owner_q <= win;
            ptr_q   <= win;
            state_q <= CALC;
          end
        end
        CALC: begin
          gnt_q   <= '0;
          sum_q   <= add_sum;
          of_q    <= add_of;
          id_q    <= owner_q;
          valid_q <= 1'b1;
          state_q <= RESULT;
        end
        RESULT: begin
          gnt_q <= '0;
          if (bus.ack_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          gnt_q   <= '0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.sum_o   = sum_q;
  assign bus.of_o    = of_q;
  assign bus.id_o    = id_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = (state_q != IDLE);
endmodule
